// File: rtl/tq_pkg.sv
// Shared definitions for the tq (transform/quant) datapath.
//   TQ_IN_W    : signed sample width entering the 16-point row stages
//   TQ_MCM_W   : width of the odd constant-multiplier inputs (TQ_IN_W+1)
//   TQ_MCM_LAT : odd constant-multiplier latency in cycles
//   beat_t     : index of a 4-sample beat within a 16-sample row
package tq_pkg;
    localparam int TQ_IN_W    = 17;
    localparam int TQ_MCM_W   = 18;
    localparam int TQ_MCM_LAT = 2;

    typedef logic [1:0] beat_t;
    localparam beat_t LAST_BEAT = 2'd3;
endpackage

// File: rtl/premcm_16_if.sv
// Beat/result bundle of premcm_16.
//   i_valid, i_clear, inverse, i_data_0..3 : row beats in (master drives)
//   o_valid, o_odd_0..7, o_even_0..7       : registered butterfly results
//   o_al_valid, o_al_even_0..7, o_al_inverse : even half aligned to the
//                                              odd multiplier output
// Modports: master = row source / result sink, slave = premcm_16.
interface premcm_16_if
    import tq_pkg::*;
#(
    parameter int IN_W = TQ_IN_W
);
    localparam int OW = IN_W + 1;

    logic                   i_valid;
    logic                   i_clear;
    logic                   inverse;
    logic signed [IN_W-1:0] i_data_0, i_data_1, i_data_2, i_data_3;

    logic                   o_valid;
    logic signed [OW-1:0]   o_odd_0, o_odd_1, o_odd_2, o_odd_3,
                            o_odd_4, o_odd_5, o_odd_6, o_odd_7;
    logic signed [OW-1:0]   o_even_0, o_even_1, o_even_2, o_even_3,
                            o_even_4, o_even_5, o_even_6, o_even_7;
    logic                   o_al_valid;
    logic signed [OW-1:0]   o_al_even_0, o_al_even_1, o_al_even_2, o_al_even_3,
                            o_al_even_4, o_al_even_5, o_al_even_6, o_al_even_7;
    logic                   o_al_inverse;

    modport master (
        output i_valid, i_clear, inverse, i_data_0, i_data_1, i_data_2, i_data_3,
        input  o_valid,
               o_odd_0, o_odd_1, o_odd_2, o_odd_3, o_odd_4, o_odd_5, o_odd_6, o_odd_7,
               o_even_0, o_even_1, o_even_2, o_even_3, o_even_4, o_even_5, o_even_6, o_even_7,
               o_al_valid,
               o_al_even_0, o_al_even_1, o_al_even_2, o_al_even_3,
               o_al_even_4, o_al_even_5, o_al_even_6, o_al_even_7,
               o_al_inverse
    );

    modport slave (
        input  i_valid, i_clear, inverse, i_data_0, i_data_1, i_data_2, i_data_3,
        output o_valid,
               o_odd_0, o_odd_1, o_odd_2, o_odd_3, o_odd_4, o_odd_5, o_odd_6, o_odd_7,
               o_even_0, o_even_1, o_even_2, o_even_3, o_even_4, o_even_5, o_even_6, o_even_7,
               o_al_valid,
               o_al_even_0, o_al_even_1, o_al_even_2, o_al_even_3,
               o_al_even_4, o_al_even_5, o_al_even_6, o_al_even_7,
               o_al_inverse
    );
endinterface

// File: rtl/tq_dly_line.sv
// Fixed-latency register chain: q_o is d_i delayed by D cycles.
//   clk, rst (async, active low, clears the chain to 0)
//   d_i [W] in, q_o [W] out
module tq_dly_line #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [D-1:0][W-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[D-1];
endmodule

// File: rtl/premcm_16.sv
// Row gather + first butterfly ahead of the 16-point DCT/IDCT odd MCM.
// A row of 16 samples arrives as 4 beats of 4. Beat 3 is combined live
// with the 12 gathered samples and the result registered:
//   forward : even_k = x[k]+x[15-k], odd_k = x[k]-x[15-k]
//   inverse : even_k = x[2k],        odd_k = x[2k+1]
// Ports: clk, rst (async active low), bus (premcm_16_if.slave).
// Parameters: IN_W sample width (outputs IN_W+1), DLY alignment depth.
// Build option PREMCM_ALIGN_EN: when defined, o_al_* are the even half,
// valid and mode delayed DLY cycles; otherwise o_al_* mirror o_* directly.
module premcm_16
    import tq_pkg::*;
#(
    parameter int IN_W = TQ_IN_W,
    parameter int DLY  = TQ_MCM_LAT
) (
    input  logic       clk,
    input  logic       rst,
    premcm_16_if.slave bus
);
    localparam int OW = IN_W + 1;

    if (DLY < 1) begin : g_bad_dly
        $error("premcm_16: DLY must be at least 1");
    end

    beat_t                 cnt_q, cnt_d;
    logic [11:0][IN_W-1:0] g_q;
    logic                  inv_q;
    logic [3:0][IN_W-1:0]  din;
    logic [15:0][IN_W-1:0] x;
    logic [7:0][OW-1:0]    even_d, odd_d, even_q, odd_q;
    logic                  vld_q, rinv_q;
    logic                  beat_ok, row_done;
    logic                  al_vld, al_inv;
    logic [7:0][OW-1:0]    al_even;

    function automatic logic [OW-1:0] sx(input logic [IN_W-1:0] v);
        return {v[IN_W-1], v};
    endfunction

    // Clear beats valid: a beat seen together with i_clear is dropped.
    assign beat_ok  = bus.i_valid && !bus.i_clear;
    assign row_done = beat_ok && (cnt_q == LAST_BEAT);
    assign din      = {bus.i_data_3, bus.i_data_2, bus.i_data_1, bus.i_data_0};
    assign x        = {din, g_q};

    always_comb begin
        cnt_d = cnt_q;
        if (bus.i_clear)      cnt_d = '0;
        else if (bus.i_valid) cnt_d = beat_t'(cnt_q + 2'd1);
        for (int k = 0; k < 8; k++) begin
            if (inv_q) begin
                even_d[k] = sx(x[2*k]);
                odd_d[k]  = sx(x[2*k+1]);
            end else begin
                even_d[k] = sx(x[k]) + sx(x[15-k]);
                odd_d[k]  = sx(x[k]) - sx(x[15-k]);
            end
        end
    end

    // Gather: clear only rewinds the counter; stale samples are overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            g_q   <= '0;
            inv_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (beat_ok) begin
                if (cnt_q == '0) inv_q <= bus.inverse;
                for (int b = 0; b < 3; b++)
                    if (cnt_q == beat_t'(b))
                        for (int j = 0; j < 4; j++) g_q[4*b+j] <= din[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            rinv_q <= 1'b0;
            even_q <= '0;
            odd_q  <= '0;
        end else begin
            vld_q <= row_done;
            if (row_done) begin
                even_q <= even_d;
                odd_q  <= odd_d;
                rinv_q <= inv_q;
            end
        end
    end

`ifdef PREMCM_ALIGN_EN
    localparam int BW = 2 + 8*OW;
    logic [BW-1:0] al_q;

    tq_dly_line #(.W(BW), .D(DLY)) u_al_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({vld_q, rinv_q, even_q}),
        .q_o (al_q)
    );
    assign {al_vld, al_inv, al_even} = al_q;
`else
    assign al_vld  = vld_q;
    assign al_inv  = rinv_q;
    assign al_even = even_q;
`endif

    assign bus.o_valid      = vld_q;
    assign bus.o_al_valid   = al_vld;
    assign bus.o_al_inverse = al_inv;
    assign bus.o_even_0 = even_q[0];  assign bus.o_even_1 = even_q[1];
    assign bus.o_even_2 = even_q[2];  assign bus.o_even_3 = even_q[3];
    assign bus.o_even_4 = even_q[4];  assign bus.o_even_5 = even_q[5];
    assign bus.o_even_6 = even_q[6];  assign bus.o_even_7 = even_q[7];
    assign bus.o_odd_0  = odd_q[0];   assign bus.o_odd_1  = odd_q[1];
    assign bus.o_odd_2  = odd_q[2];   assign bus.o_odd_3  = odd_q[3];
    assign bus.o_odd_4  = odd_q[4];   assign bus.o_odd_5  = odd_q[5];
    assign bus.o_odd_6  = odd_q[6];   assign bus.o_odd_7  = odd_q[7];
    assign bus.o_al_even_0 = al_even[0];  assign bus.o_al_even_1 = al_even[1];
    assign bus.o_al_even_2 = al_even[2];  assign bus.o_al_even_3 = al_even[3];
    assign bus.o_al_even_4 = al_even[4];  assign bus.o_al_even_5 = al_even[5];
    assign bus.o_al_even_6 = al_even[6];  assign bus.o_al_even_7 = al_even[7];
endmodule

// File: tb/tb_premcm_16.sv
// Scoreboard bench for premcm_16: expected rows are queued when beat 3 is
// driven and compared when o_valid / o_al_valid pulse.
module tb_premcm_16;
    import tq_pkg::*;

    localparam int DLY = 2;
`ifdef PREMCM_ALIGN_EN
    localparam int AL = DLY;
`else
    localparam int AL = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    premcm_16_if #(.IN_W(17)) bus ();

    premcm_16 #(.IN_W(17), .DLY(DLY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0][31:0] ev;
        logic [7:0][31:0] od;
        logic             inv;
        logic [31:0]      cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t al_q[$];
    exp_t me, ma;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    logic signed [17:0] ev_o[8], od_o[8], al_o[8];
    assign ev_o[0] = bus.o_even_0; assign ev_o[1] = bus.o_even_1;
    assign ev_o[2] = bus.o_even_2; assign ev_o[3] = bus.o_even_3;
    assign ev_o[4] = bus.o_even_4; assign ev_o[5] = bus.o_even_5;
    assign ev_o[6] = bus.o_even_6; assign ev_o[7] = bus.o_even_7;
    assign od_o[0] = bus.o_odd_0;  assign od_o[1] = bus.o_odd_1;
    assign od_o[2] = bus.o_odd_2;  assign od_o[3] = bus.o_odd_3;
    assign od_o[4] = bus.o_odd_4;  assign od_o[5] = bus.o_odd_5;
    assign od_o[6] = bus.o_odd_6;  assign od_o[7] = bus.o_odd_7;
    assign al_o[0] = bus.o_al_even_0; assign al_o[1] = bus.o_al_even_1;
    assign al_o[2] = bus.o_al_even_2; assign al_o[3] = bus.o_al_even_3;
    assign al_o[4] = bus.o_al_even_4; assign al_o[5] = bus.o_al_even_5;
    assign al_o[6] = bus.o_al_even_6; assign al_o[7] = bus.o_al_even_7;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Monitor: outputs are registered, so the falling edge is a stable sample.
    always @(negedge clk) begin
        if (bus.o_valid) begin
            if (sb_q.size() == 0) chk("spurious_vld", 1, 0);
            else begin
                me = sb_q.pop_front();
                chk("vld_cyc", cyc, int'(me.cyc));
                for (int k = 0; k < 8; k++) begin
                    chk($sformatf("even%0d", k), ev_o[k], int'(me.ev[k]));
                    chk($sformatf("odd%0d", k),  od_o[k], int'(me.od[k]));
                end
            end
        end
        if (bus.o_al_valid) begin
            if (al_q.size() == 0) chk("spurious_al_vld", 1, 0);
            else begin
                ma = al_q.pop_front();
                chk("al_cyc", cyc, int'(ma.cyc));
                chk("al_inv", int'(bus.o_al_inverse), int'(ma.inv));
                for (int k = 0; k < 8; k++)
                    chk($sformatf("al_even%0d", k), al_o[k], int'(ma.ev[k]));
            end
        end
    end

    task automatic push_exp(input int x[16], input logic inv);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            if (inv) begin
                e.ev[k] = 32'(x[2*k]);
                e.od[k] = 32'(x[2*k+1]);
            end else begin
                e.ev[k] = 32'(x[k] + x[15-k]);
                e.od[k] = 32'(x[k] - x[15-k]);
            end
        end
        e.inv = inv;
        e.cyc = 32'(cyc + 1);
        sb_q.push_back(e);
        e.cyc = 32'(cyc + 1 + AL);
        al_q.push_back(e);
    endtask

    task automatic drive_beat(input int x[16], input int b, input logic inv);
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_clear  = 1'b0;
        bus.inverse  = inv;
        bus.i_data_0 = 17'(x[4*b]);
        bus.i_data_1 = 17'(x[4*b+1]);
        bus.i_data_2 = 17'(x[4*b+2]);
        bus.i_data_3 = 17'(x[4*b+3]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_valid = 1'b0;
            bus.i_clear = 1'b0;
        end
    endtask

    // tog flips 'inverse' on beats 1..3; gap inserts idle cycles between beats.
    task automatic send_row(input int x[16], input logic inv, input bit tog, input int gap);
        for (int b = 0; b < 4; b++) begin
            drive_beat(x, b, (tog && b > 0) ? ~inv : inv);
            if (b == 3) push_exp(x, inv);
            else if (gap > 0) idle(gap);
        end
    endtask

    initial begin
        int x[16];
        int y[16];
        int z[16];
        bus.i_valid = 1'b0; bus.i_clear = 1'b0; bus.inverse = 1'b0;
        bus.i_data_0 = '0; bus.i_data_1 = '0; bus.i_data_2 = '0; bus.i_data_3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_vld",    int'(bus.o_valid), 0);
        chk("rst_even0",  ev_o[0], 0);
        chk("rst_odd7",   od_o[7], 0);
        chk("rst_alvld",  int'(bus.o_al_valid), 0);
        chk("rst_aleven3", al_o[3], 0);
        chk("rst_alinv",  int'(bus.o_al_inverse), 0);
        rst = 1'b1;

        // forward ramp: even = 15, odd = 2k-15
        for (int n = 0; n < 16; n++) x[n] = n;
        send_row(x, 1'b0, 1'b0, 0);
        idle(5);

        // inverse split with the mode toggled on beats 1..3
        for (int n = 0; n < 16; n++) x[n] = 100 + n;
        send_row(x, 1'b1, 1'b1, 0);
        idle(5);

        // extremes: even = -1, odd = -131071
        for (int k = 0; k < 8; k++) begin x[k] = -65536; x[15-k] = 65535; end
        send_row(x, 1'b0, 1'b0, 0);
        idle(3);

        // partial row, clear with valid high, then fresh row with gaps
        for (int n = 0; n < 16; n++) begin y[n] = 1000 + 7*n; z[n] = -300 + 41*n; end
        drive_beat(y, 0, 1'b1);
        idle(2);
        drive_beat(y, 1, 1'b1);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_clear = 1'b1; bus.i_data_0 = 17'sd5000;
        send_row(z, 1'b0, 1'b0, 1);
        idle(5);

        // random rows, back to back
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 16; n++) x[n] = int'($urandom_range(131071)) - 65536;
            send_row(x, 1'($urandom_range(1)), 1'b0, 0);
        end
        idle(6);

        // back-to-back rows, reset while the third row starts
        for (int n = 0; n < 16; n++) begin y[n] = 3*n - 20; z[n] = 500 - 9*n; end
        send_row(y, 1'b0, 1'b0, 0);
        send_row(z, 1'b1, 1'b0, 0);
        drive_beat(y, 0, 1'b0);
        @(negedge clk);
        while (al_q.size() > 0 && int'(al_q[$].cyc) > cyc) void'(al_q.pop_back());
        while (sb_q.size() > 0 && int'(sb_q[$].cyc) > cyc) void'(sb_q.pop_back());
        rst = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        chk("rstmid_vld",    int'(bus.o_valid), 0);
        chk("rstmid_even0",  ev_o[0], 0);
        chk("rstmid_odd3",   od_o[3], 0);
        chk("rstmid_alvld",  int'(bus.o_al_valid), 0);
        chk("rstmid_aleven0", al_o[0], 0);
        chk("rstmid_alinv",  int'(bus.o_al_inverse), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // first beat after release must be beat 0
        for (int n = 0; n < 16; n++) x[n] = 15 - 2*n;
        send_row(x, 1'b0, 1'b0, 0);
        idle(8);

        chk("sb_drain", sb_q.size(), 0);
        chk("al_drain", al_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
